// File: rtl/sha256_msg_ctrl.sv
// sha256_msg_ctrl
// ---------------------------------------------------------------------------
// Message-level sequencer for the single-block SHA-256 compression core
// (sha256_block). It takes pre-padded 512-bit blocks from the padding/DMA
// front end and starts the core once per block. It chains the compression
// results across the blocks of a message. It then presents the final 256-bit
// digest to the consumer. The controller owns the core exclusively.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The sender holds valid, and its payload stable, until that
// edge. Ready never waits for valid. blk_ready is high only in IDLE/NEXT and
// dig_valid only in OUT, so a block is never taken while a digest is pending.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   blk_valid      block offered by the front end
//   blk_ready      controller can accept a block (IDLE / NEXT)
//   blk_data       padded block, word 0 at [511:480]
//   blk_first      block starts a new message (only meaningful in NEXT)
//   blk_last       block ends the message
//   dig_valid      digest available (OUT)
//   dig_ready      consumer accepts the digest
//   dig_data       digest, word a at [255:224] (always the chain register)
//   core_start     one-cycle start pulse to the core (input_valid)
//   core_h_in      chaining value to the core (H_in)
//   core_m_in      message block to the core (M_in)
//   core_h_out     core result (H_out), valid only while core_done is high
//   core_done      core result strobe (output_valid)
//   busy           high in every state except IDLE
//   blk_count      blocks completed in the current message (wraps)
//   err_timeout    one-cycle pulse when a block is abandoned for lack of done
//   state_dbg      current FSM state encoding, for checkers and debug
// ---------------------------------------------------------------------------
module sha256_msg_ctrl #(
    parameter int TIMEOUT = 80,   // RUN cycles without core_done before abort (> 65)
    parameter int CNT_W   = 16    // width of blk_count
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               blk_valid,
    output logic               blk_ready,
    input  logic [511:0]       blk_data,
    input  logic               blk_first,
    input  logic               blk_last,
    output logic               dig_valid,
    input  logic               dig_ready,
    output logic [255:0]       dig_data,
    output logic               core_start,
    output logic [255:0]       core_h_in,
    output logic [511:0]       core_m_in,
    input  logic [255:0]       core_h_out,
    input  logic               core_done,
    output logic               busy,
    output logic [CNT_W-1:0]   blk_count,
    output logic               err_timeout,
    output logic [2:0]         state_dbg
);

    // SHA-256 initial hash value, word a first.
    localparam logic [255:0] IHV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_NEXT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t              state;
    logic [255:0]        chain;
    logic [511:0]        m_reg;
    logic                last_reg;
    logic [TCNT_W-1:0]   tcnt;
    logic                timeout_hit;

    // The abort has to be visible in the very cycle the counter reaches its
    // limit, and done in that same cycle still wins. So this pulse is decoded
    // from registered state and the live done input, not registered itself.
    assign timeout_hit = (state == S_RUN) && !core_done && (tcnt == TCNT_LAST);
    assign err_timeout = timeout_hit;

    // The core adds H_in to its final state, so chain feeds it directly and
    // is left untouched from START until the capture cycle.
    assign core_h_in = chain;
    assign core_m_in = m_reg;
    assign dig_data  = chain;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            chain      <= IHV;
            m_reg      <= '0;
            last_reg   <= 1'b0;
            tcnt       <= '0;
            blk_count  <= '0;
            blk_ready  <= 1'b1;
            dig_valid  <= 1'b0;
            core_start <= 1'b0;
            busy       <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Every block taken in IDLE opens a new message,
                    // whatever blk_first says.
                    if (blk_valid) begin
                        m_reg      <= blk_data;
                        last_reg   <= blk_last;
                        chain      <= IHV;
                        blk_count  <= '0;
                        state      <= S_START;
                        blk_ready  <= 1'b0;
                        core_start <= 1'b1;
                        busy       <= 1'b1;
                    end
                end

                S_START: begin
                    tcnt  <= '0;
                    state <= S_RUN;
                end

                S_RUN: begin
                    tcnt <= tcnt + 1'b1;
                    if (core_done) begin
                        chain     <= core_h_out;
                        blk_count <= blk_count + 1'b1;
                        if (last_reg) begin
                            state     <= S_OUT;
                            dig_valid <= 1'b1;
                        end else begin
                            state     <= S_NEXT;
                            blk_ready <= 1'b1;
                        end
                    end else if (tcnt == TCNT_LAST) begin
                        // Abandon the whole message; the core is restarted
                        // by whichever block comes next.
                        state     <= S_IDLE;
                        chain     <= IHV;
                        blk_count <= '0;
                        blk_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                S_NEXT: begin
                    if (blk_valid) begin
                        m_reg    <= blk_data;
                        last_reg <= blk_last;
                        // A new message arriving here drops the one in flight.
                        if (blk_first) begin
                            chain     <= IHV;
                            blk_count <= '0;
                        end
                        state      <= S_START;
                        blk_ready  <= 1'b0;
                        core_start <= 1'b1;
                    end
                end

                S_OUT: begin
                    // blk_count keeps showing the finished message until the
                    // next one is accepted.
                    if (dig_ready) begin
                        state     <= S_IDLE;
                        chain     <= IHV;
                        dig_valid <= 1'b0;
                        blk_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    chain     <= IHV;
                    blk_count <= '0;
                    blk_ready <= 1'b1;
                    dig_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Structural invariants of the controller.
    a_start_pulse: assert property (@(posedge clk) disable iff (rst)
        core_start |=> !core_start);

    a_ready_excl: assert property (@(posedge clk) disable iff (rst)
        !(blk_ready && dig_valid));

    a_chain_hold: assert property (@(posedge clk) disable iff (rst)
        ((state == S_START) || (state == S_RUN && !core_done && !timeout_hit))
        |=> $stable(chain));

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Testbench for sha256_msg_ctrl. A behavioural SHA-256 compression core
// answers each core_start 65 cycles later. Expected digests are published
// test vectors, queued when a message's last block is sent and compared at
// the digest handshake.
module tb_sha256_msg_ctrl;

    localparam int CNT_W = 16;

    localparam logic [255:0] IHV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] TWO_DIG =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- DUT signals ----------------
    logic               clk;
    logic               rst;
    logic               blk_valid;
    logic               blk_ready;
    logic [511:0]       blk_data;
    logic               blk_first;
    logic               blk_last;
    logic               dig_valid;
    logic               dig_ready;
    logic [255:0]       dig_data;
    logic               core_start;
    logic [255:0]       core_h_in;
    logic [511:0]       core_m_in;
    logic [255:0]       core_h_out;
    logic               core_done;
    logic               busy;
    logic [CNT_W-1:0]   blk_count;
    logic               err_timeout;
    logic [2:0]         state_dbg;

    sha256_msg_ctrl #(.TIMEOUT(80), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .blk_valid   (blk_valid),
        .blk_ready   (blk_ready),
        .blk_data    (blk_data),
        .blk_first   (blk_first),
        .blk_last    (blk_last),
        .dig_valid   (dig_valid),
        .dig_ready   (dig_ready),
        .dig_data    (dig_data),
        .core_start  (core_start),
        .core_h_in   (core_h_in),
        .core_m_in   (core_m_in),
        .core_h_out  (core_h_out),
        .core_done   (core_done),
        .busy        (busy),
        .blk_count   (blk_count),
        .err_timeout (err_timeout),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [255:0]     exp_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- SHA-256 compression model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            s1 = ror(e, 6) ^ ror(e, 11) ^ ror(e, 25);
            t1 = hh + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
            s0 = ror(a, 2) ^ ror(a, 13) ^ ror(a, 22);
            t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96]  + e, h[95:64]   + f, h[63:32]   + g, h[31:0]    + hh};
    endfunction

    // Core model: done and result appear 65 cycles after the start cycle;
    // H_out is zero whenever done is low.
    logic         core_dead;
    int           core_rem;
    logic [255:0] core_res;

    always @(posedge clk) begin
        core_done  <= 1'b0;
        core_h_out <= '0;
        if (rst) begin
            core_rem <= 0;
        end else if (core_start) begin
            core_res <= sha_compress(core_h_in, core_m_in);
            core_rem <= core_dead ? 0 : 64;
        end else if (core_rem > 0) begin
            core_rem <= core_rem - 1;
            if (core_rem == 1) begin
                core_done  <= 1'b1;
                core_h_out <= core_res;
            end
        end
    end

    // Monitors sampled on the falling edge.
    int start_cnt = 0;
    int start_back2back = 0;
    int overlap_cnt = 0;
    logic start_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) start_cnt++;
            if (core_start && start_prev) start_back2back++;
            if (blk_ready && dig_valid) overlap_cnt++;
        end
        start_prev = core_start;
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_block(input logic [511:0] d, input logic f, input logic l);
        int n = 0;
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("blk_ready_wait", blk_ready, 1'b1);
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        blk_valid = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = '0;
    endtask

    // Counts the cycles with blk_ready low after a non-last block is sent.
    task automatic wait_next(input string tag);
        int n = 0;
        while (!blk_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        check_eq(tag, n, 66);
    endtask

    task automatic recv_digest(input int hold);
        int n = 0;
        int bad = 0;
        logic [255:0]     e;
        logic [CNT_W-1:0] c;
        while (!dig_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("dig_valid_wait", dig_valid, 1'b1);
        if (dig_valid) begin
            for (int i = 0; i < hold; i++) begin
                if (!dig_valid || blk_ready || core_start || exp_q.size() == 0 ||
                    dig_data !== exp_q[0])
                    bad++;
                @(negedge clk);
            end
            if (hold > 0) check_eq("hold_stable", bad, 0);
            dig_ready = 1'b1;
            check_eq("exp_q_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = exp_cnt_q.pop_front();
                check_eq("digest", dig_data, e);
                check_eq("blk_count_out", blk_count, c);
            end
            @(negedge clk);
            dig_ready = 1'b0;
            check_eq("idle_blk_ready", blk_ready, 1'b1);
            check_eq("idle_busy", busy, 1'b0);
            check_eq("idle_dig_valid", dig_valid, 1'b0);
            check_eq("idle_dig_data", dig_data, IHV);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [511:0] abc_blk;
    logic [511:0] two_blk1;
    logic [511:0] two_blk2;

    initial begin
        int n;
        int starts_exp;
        abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
        two_blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_blk2 = {448'h0, 32'h00000000, 32'h000001c0};

        rst = 1'b1; blk_valid = 1'b0; blk_data = '0; blk_first = 1'b0;
        blk_last = 1'b0; dig_ready = 1'b0; core_dead = 1'b0;
        starts_exp = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_eq("rst_blk_ready", blk_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_dig_valid", dig_valid, 1'b0);
        check_eq("rst_core_start", core_start, 1'b0);
        check_eq("rst_blk_count", blk_count, 0);
        check_eq("rst_err_timeout", err_timeout, 1'b0);
        check_eq("rst_dig_data", dig_data, IHV);
        check_eq("rst_state", state_dbg, 0);

        // Single "abc" block: digest 67 cycles after acceptance.
        send_block(abc_blk, 1'b1, 1'b1);
        starts_exp += 1;
        exp_q.push_back(ABC_DIG); exp_cnt_q.push_back(1);
        check_eq("start_busy", busy, 1'b1);
        check_eq("start_blk_ready", blk_ready, 1'b0);
        check_eq("start_pulse", core_start, 1'b1);
        n = 1;
        while (!dig_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("abc_latency", n, 67);
        recv_digest($urandom_range(0, 3));

        // Two-block message with producer idle time in NEXT.
        send_block(two_blk1, 1'b1, 1'b0);
        wait_next("two_blk1_busy_cycles");
        check_eq("next_blk_count", blk_count, 1);
        repeat ($urandom_range(0, 6)) @(negedge clk);
        send_block(two_blk2, 1'b0, 1'b1);
        starts_exp += 2;
        exp_q.push_back(TWO_DIG); exp_cnt_q.push_back(2);
        n = 0;
        while (!dig_valid && n < 400) begin
            if (blk_ready) n = 1000;
            else n++;
            @(negedge clk);
        end
        check_eq("two_blk2_busy_cycles", n, 66);
        recv_digest(0);

        // Digest held for 20 cycles.
        send_block(abc_blk, 1'b1, 1'b1);
        starts_exp += 1;
        exp_q.push_back(ABC_DIG); exp_cnt_q.push_back(1);
        recv_digest(20);

        // New message (first=1) in NEXT abandons the in-flight one.
        send_block(two_blk1, 1'b1, 1'b0);
        wait_next("abandon_busy_cycles");
        send_block(abc_blk, 1'b1, 1'b1);
        starts_exp += 2;
        exp_q.push_back(ABC_DIG); exp_cnt_q.push_back(1);
        recv_digest($urandom_range(0, 3));

        // Core never answers: timeout abort, then a normal block.
        core_dead = 1'b1;
        send_block(abc_blk, 1'b1, 1'b1);
        starts_exp += 1;
        n = 1;
        while (!err_timeout && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_cycle", n, 81);
        check_eq("timeout_no_dig", dig_valid, 1'b0);
        @(negedge clk);
        core_dead = 1'b0;
        check_eq("timeout_pulse_end", err_timeout, 1'b0);
        check_eq("timeout_blk_ready", blk_ready, 1'b1);
        check_eq("timeout_busy", busy, 1'b0);
        check_eq("timeout_blk_count", blk_count, 0);
        check_eq("timeout_chain", dig_data, IHV);
        send_block(abc_blk, 1'b1, 1'b1);
        starts_exp += 1;
        exp_q.push_back(ABC_DIG); exp_cnt_q.push_back(1);
        recv_digest(0);

        // Reset 30 cycles into RUN of a second block.
        send_block(two_blk1, 1'b1, 1'b0);
        wait_next("rst_case_busy_cycles");
        send_block(two_blk2, 1'b0, 1'b1);
        starts_exp += 2;
        repeat (31) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_blk_ready", blk_ready, 1'b1);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_blk_count", blk_count, 0);
        check_eq("midrst_dig_valid", dig_valid, 1'b0);
        check_eq("midrst_chain", dig_data, IHV);
        n = 0;
        for (int i = 0; i < 80; i++) begin
            if (dig_valid || core_start || !blk_ready) n++;
            @(negedge clk);
        end
        check_eq("midrst_quiet", n, 0);
        // blk_first is ignored in IDLE.
        send_block(abc_blk, 1'b0, 1'b1);
        starts_exp += 1;
        exp_q.push_back(ABC_DIG); exp_cnt_q.push_back(1);
        recv_digest($urandom_range(1, 4));

        // End-of-run totals.
        repeat (2) @(negedge clk);
        check_eq("start_count", start_cnt, starts_exp);
        check_eq("start_single_cycle", start_back2back, 0);
        check_eq("ready_valid_overlap", overlap_cnt, 0);
        check_eq("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sha256_msg_ctrl.md
Name: sha256_msg_ctrl

Overview:
Message-level sequencer for the single-block SHA-256 compression core (sha256_block).
- Accepts a stream of pre-padded 512-bit blocks over a valid/ready handshake, with first/last flags.
- Starts the core once per block and holds the chaining value on the core's H_in for the whole compression.
- Captures the core result on done, and presents the final 256-bit digest over a valid/ready handshake.
- Sits between the padding/DMA front end and the digest consumer; it owns the core exclusively.

Parameters:
TIMEOUT, 80, cycles in RUN without core_done before the block is abandoned (must be >65)
CNT_W, 16, width of the per-message block counter

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high
blk_valid  input  1  block offered
blk_ready  output  1  controller can accept a block
blk_data  input  512  padded message block, word 0 at [511:480]
blk_first  input  1  block starts a new message
blk_last  input  1  block ends the message
dig_valid  output  1  digest available
dig_ready  input  1  consumer accepts digest
dig_data  output  256  digest, word a at [255:224]
core_start  output  1  to core input_valid, one-cycle pulse
core_h_in  output  256  to core H_in (chaining value)
core_m_in  output  512  to core M_in
core_h_out  input  256  from core H_out
core_done  input  1  from core output_valid
busy  output  1  high in any state but IDLE
blk_count  output  CNT_W  blocks completed in the current message
err_timeout  output  1  one-cycle pulse on timeout abort

Behaviour:
- States: IDLE, START, RUN, NEXT, OUT. Registers: chain[255:0], m_reg[511:0], last_reg, tcnt, blk_count.
- Reset values: state=IDLE, chain=IHV (6A09E667 BB67AE85 3C6EF372 A54FF53A 510E527F 9B05688C 1F83D9AB 5BE0CD19), m_reg=0, blk_count=0, tcnt=0. All outputs go to their IDLE values: blk_ready=1, others 0. core_h_in=chain, core_m_in=m_reg, dig_data=chain at all times.
- IDLE: blk_ready=1. On blk_valid: m_reg<=blk_data, last_reg<=blk_last, chain<=IHV, blk_count<=0, then go to START. blk_first is ignored in IDLE; the block is always treated as first.
- START: core_start=1 for exactly one cycle. tcnt<=0. Go to RUN.
- RUN: tcnt increments each cycle.
  - On core_done: chain<=core_h_out and blk_count<=blk_count+1. Go to OUT if last_reg, else NEXT.
  - core_done is sampled only in RUN. With sha256_block, done arrives 65 cycles after the START cycle; the result is valid only in that cycle.
  - If tcnt reaches TIMEOUT-1 without done: err_timeout=1 for that cycle, then go to IDLE. chain and blk_count return to reset values and the message is dropped.
- NEXT: blk_ready=1. On blk_valid: m_reg<=blk_data and last_reg<=blk_last.
  - If blk_first=1, the in-flight message is abandoned: chain<=IHV and blk_count<=0 before going to START.
  - Otherwise chain is kept. Go to START.
- OUT: dig_valid=1, dig_data=chain. Held stable until dig_ready. On dig_ready go to IDLE, with chain<=IHV.
- blk_ready is asserted only in IDLE and NEXT. dig_valid is asserted only in OUT. Blocks are never accepted while a digest is pending.
- chain must not change between START and the capture cycle; the core adds H_in to its final state.
- Latency: block accepted at edge of cycle 0 → START in cycle 1 → core_done in cycle 66 → dig_valid in cycle 67 for a single-block message. Each additional block adds 67 cycles plus any producer idle time in NEXT.
- blk_count wraps modulo 2^CNT_W.
- rst mid-operation: immediate return to reset values.
  - No core_start is issued during reset.
  - The core's internal state is don't-care; the next block restarts it.

Test Plan:
- Single block "abc" (61626380 00…00 00000018) with first=last=1 → dig_valid exactly 67 cycles after acceptance; dig_data=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; blk_count=1.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second block first=0, last=1) → digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; blk_count=2; blk_ready low throughout each START/RUN.
- Hold dig_ready=0 for 20 cycles in OUT → dig_valid and dig_data stable, blk_ready=0, no core_start. Then dig_ready=1 for one cycle → IDLE next cycle with blk_ready=1.
- Send block 1 of the two-block message, then the "abc" block with first=1, last=1 in NEXT → digest equals the "abc" digest.
- Core stub never asserts done → err_timeout pulses in the cycle when tcnt=79 after START; state returns to IDLE with blk_ready=1; a following "abc" block then hashes correctly.
- Assert rst for 1 cycle at RUN cycle 30 → next cycle blk_ready=1, busy=0, blk_count=0, no dig_valid. A subsequent "abc" block hashes correctly.
